dma_channel_bank: RTL and testbench

- Parametrised per-channel address/word-count register bank for the DMA controller.
- Holds base, current and mode state for NUM_CH channels of REG_W-bit registers, programmed byte-serially over the 8-bit CPU data path through a byte-pointer counter.
- Steps the current address and count once per transfer, raises terminal count, and auto-reloads from base on request.
- Sits between the CPU bus interface and the timing/control FSM, replacing the fixed 4-channel 16-bit register bank.

---
 rtl/dma_channel_bank.sv | 208 ++++++++++++++++++++
 tb/tb_dma_channel_bank.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_channel_bank.sv
// Per-channel base/current address, count and mode registers for the DMA controller,
// programmed byte-serially from the CPU. Optional AddrHold mode bit: DMA_BANK_ADDR_HOLD_EN.
module dma_channel_bank #(
  parameter  int unsigned NUM_CH = 4,
  parameter  int unsigned REG_W  = 16,
  parameter  int unsigned CH_W   = $clog2(NUM_CH),
  localparam int unsigned NB     = REG_W / 8,
  localparam int unsigned BP_W   = (NB > 1) ? $clog2(NB) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              master_clear_i,
  input  logic              clear_byte_ptr_i,
  input  logic              cpu_wr_i,
  input  logic              cpu_rd_i,
  input  logic [1:0]        reg_sel_i,
  input  logic [CH_W-1:0]   ch_sel_i,
  input  logic [7:0]        data_i,
  output logic [7:0]        data_o,
  input  logic              xfer_step_i,
  input  logic [CH_W-1:0]   xfer_ch_i,
  output logic [REG_W-1:0]  cur_addr_o,
  output logic [REG_W-1:0]  cur_count_o,
  output logic [NUM_CH-1:0] tc_pulse_o,
  output logic [NUM_CH-1:0] tc_status_o,
  output logic [NUM_CH-1:0] auto_init_o,
  output logic [BP_W-1:0]   byte_ptr_o
);

  typedef enum logic [1:0] {
    SEL_ADDR   = 2'd0,
    SEL_COUNT  = 2'd1,
    SEL_MODE   = 2'd2,
    SEL_STATUS = 2'd3
  } reg_sel_e;

  // Mode register keeps the CPU byte's bit numbering, so bit 4 is AutoInit.
  localparam int unsigned M_HOLD = 3;
  localparam int unsigned M_AUTO = 4;
  localparam int unsigned M_DEC  = 5;

  logic [REG_W-1:0]  base_addr_q [NUM_CH];
  logic [REG_W-1:0]  base_addr_d [NUM_CH];
  logic [REG_W-1:0]  base_cnt_q  [NUM_CH];
  logic [REG_W-1:0]  base_cnt_d  [NUM_CH];
  logic [REG_W-1:0]  cur_addr_q  [NUM_CH];
  logic [REG_W-1:0]  cur_addr_d  [NUM_CH];
  logic [REG_W-1:0]  cur_cnt_q   [NUM_CH];
  logic [REG_W-1:0]  cur_cnt_d   [NUM_CH];
  logic [7:2]        mode_q      [NUM_CH];
  logic [7:2]        mode_d      [NUM_CH];
  logic [BP_W-1:0]   ptr_q, ptr_d;
  logic [7:0]        data_q, data_d;
  logic [NUM_CH-1:0] tc_pulse_q, tc_pulse_d;
  logic [NUM_CH-1:0] tc_status_q, tc_status_d;

  reg_sel_e          sel;
  logic              wr_en;
  logic              rd_en;
  logic              step_blocked;
  logic              addr_hold;
  logic [7:2]        step_mode;
  logic [REG_W-1:0]  step_addr;
  logic [NUM_CH-1:0] tc_set;
  logic              tc_clr;
  logic [7:0]        status_byte;
  int unsigned       bit_off;

  assign sel   = reg_sel_e'(reg_sel_i);
  assign wr_en = cpu_wr_i;
  // A simultaneous read is discarded in favour of the write.
  assign rd_en = cpu_rd_i & ~cpu_wr_i;

  always_comb begin
    status_byte = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      status_byte[i] = tc_status_q[i];
    end
  end

  always_comb begin
    auto_init_o = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      auto_init_o[i] = mode_q[i][M_AUTO];
    end
  end

  always_comb begin
    step_mode = mode_q[xfer_ch_i];
`ifdef DMA_BANK_ADDR_HOLD_EN
    addr_hold = step_mode[M_HOLD];
`else
    addr_hold = 1'b0;
`endif
    if (addr_hold) begin
      step_addr = cur_addr_q[xfer_ch_i];
    end else if (step_mode[M_DEC]) begin
      step_addr = cur_addr_q[xfer_ch_i] - REG_W'(1);
    end else begin
      step_addr = cur_addr_q[xfer_ch_i] + REG_W'(1);
    end
  end

  always_comb begin
    base_addr_d = base_addr_q;
    base_cnt_d  = base_cnt_q;
    cur_addr_d  = cur_addr_q;
    cur_cnt_d   = cur_cnt_q;
    mode_d      = mode_q;
    ptr_d       = ptr_q;
    data_d      = data_q;
    tc_pulse_d  = '0;
    tc_set      = '0;
    tc_clr      = 1'b0;
    bit_off     = 32'(ptr_q) << 3;

    // Step is applied first so a same-channel CPU write below can overwrite it;
    // the step is fully suppressed in that case so no TC is raised either.
    step_blocked = wr_en && (sel != SEL_STATUS) && (ch_sel_i == xfer_ch_i);
    if (xfer_step_i && !step_blocked) begin
      if (cur_cnt_q[xfer_ch_i] == '0) begin
        tc_pulse_d[xfer_ch_i] = 1'b1;
        tc_set[xfer_ch_i]     = 1'b1;
        if (step_mode[M_AUTO]) begin
          cur_addr_d[xfer_ch_i] = base_addr_q[xfer_ch_i];
          cur_cnt_d[xfer_ch_i]  = base_cnt_q[xfer_ch_i];
        end else begin
          cur_addr_d[xfer_ch_i] = step_addr;
          cur_cnt_d[xfer_ch_i]  = '1;
        end
      end else begin
        cur_addr_d[xfer_ch_i] = step_addr;
        cur_cnt_d[xfer_ch_i]  = cur_cnt_q[xfer_ch_i] - REG_W'(1);
      end
    end

    if (wr_en) begin
      case (sel)
        SEL_ADDR: begin
          base_addr_d[ch_sel_i][bit_off +: 8] = data_i;
          cur_addr_d[ch_sel_i][bit_off +: 8]  = data_i;
        end
        SEL_COUNT: begin
          base_cnt_d[ch_sel_i][bit_off +: 8] = data_i;
          cur_cnt_d[ch_sel_i][bit_off +: 8]  = data_i;
        end
        SEL_MODE: mode_d[ch_sel_i] = data_i[7:2];
        default: ;
      endcase
    end

    if (rd_en) begin
      case (sel)
        SEL_ADDR:  data_d = cur_addr_q[ch_sel_i][bit_off +: 8];
        SEL_COUNT: data_d = cur_cnt_q[ch_sel_i][bit_off +: 8];
        SEL_MODE:  data_d = {mode_q[ch_sel_i], 2'b00};
        default: begin
          data_d = status_byte;
          tc_clr = 1'b1;
        end
      endcase
    end

    if (clear_byte_ptr_i) begin
      ptr_d = '0;
    end else if ((cpu_wr_i || cpu_rd_i) && (sel == SEL_ADDR || sel == SEL_COUNT)) begin
      ptr_d = (ptr_q == BP_W'(NB - 1)) ? '0 : ptr_q + BP_W'(1);
    end

    tc_status_d = (tc_clr ? '0 : tc_status_q) | tc_set;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || master_clear_i) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        base_addr_q[i] <= '0;
        base_cnt_q[i]  <= '0;
        cur_addr_q[i]  <= '0;
        cur_cnt_q[i]   <= '0;
        mode_q[i]      <= '0;
      end
      ptr_q       <= '0;
      data_q      <= '0;
      tc_pulse_q  <= '0;
      tc_status_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        base_addr_q[i] <= base_addr_d[i];
        base_cnt_q[i]  <= base_cnt_d[i];
        cur_addr_q[i]  <= cur_addr_d[i];
        cur_cnt_q[i]   <= cur_cnt_d[i];
        mode_q[i]      <= mode_d[i];
      end
      ptr_q       <= ptr_d;
      data_q      <= data_d;
      tc_pulse_q  <= tc_pulse_d;
      tc_status_q <= tc_status_d;
    end
  end

  assign data_o      = data_q;
  assign byte_ptr_o  = ptr_q;
  assign tc_pulse_o  = tc_pulse_q;
  assign tc_status_o = tc_status_q;
  assign cur_addr_o  = cur_addr_q[xfer_ch_i];
  assign cur_count_o = cur_cnt_q[xfer_ch_i];

endmodule

// File: tb/tb_dma_channel_bank.sv
// Self-checking bench for dma_channel_bank: directed scenarios plus randomized traffic
// compared against a transaction-level model of the register bank.
module tb_dma_channel_bank;
  localparam int unsigned NUM_CH = 4;
  localparam int unsigned REG_W  = 16;
  localparam int unsigned CH_W   = 2;
  localparam int unsigned BP_W   = 1;

  logic              clk;
  logic              rst_n;
  logic              mclr;
  logic              clr_ptr;
  logic              cpu_wr;
  logic              cpu_rd;
  logic [1:0]        reg_sel;
  logic [CH_W-1:0]   ch_sel;
  logic [7:0]        din;
  logic [7:0]        dout;
  logic              step;
  logic [CH_W-1:0]   xfer_ch;
  logic [REG_W-1:0]  cur_addr;
  logic [REG_W-1:0]  cur_count;
  logic [NUM_CH-1:0] tc_pulse;
  logic [NUM_CH-1:0] tc_status;
  logic [NUM_CH-1:0] auto_init;
  logic [BP_W-1:0]   byte_ptr;

  int checks;
  int failures;

  // Model state: whole 16-bit registers, updated once per clock from the spec rules.
  logic [15:0] m_base_addr [4];
  logic [15:0] m_base_cnt  [4];
  logic [15:0] m_cur_addr  [4];
  logic [15:0] m_cur_cnt   [4];
  logic [7:0]  m_mode      [4];
  int unsigned m_ptr;
  logic [7:0]  m_dout;
  logic [3:0]  m_tcp;
  logic [3:0]  m_tcs;

  dma_channel_bank #(.NUM_CH(NUM_CH), .REG_W(REG_W)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .master_clear_i   (mclr),
    .clear_byte_ptr_i (clr_ptr),
    .cpu_wr_i         (cpu_wr),
    .cpu_rd_i         (cpu_rd),
    .reg_sel_i        (reg_sel),
    .ch_sel_i         (ch_sel),
    .data_i           (din),
    .data_o           (dout),
    .xfer_step_i      (step),
    .xfer_ch_i        (xfer_ch),
    .cur_addr_o       (cur_addr),
    .cur_count_o      (cur_count),
    .tc_pulse_o       (tc_pulse),
    .tc_status_o      (tc_status),
    .auto_init_o      (auto_init),
    .byte_ptr_o       (byte_ptr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] put_byte(input logic [15:0] v, input int unsigned idx,
                                           input logic [7:0] b);
    logic [15:0] mask;
    mask = 16'hFF << (8 * idx);
    return (v & ~mask) | (16'(b) << (8 * idx));
  endfunction

  function automatic logic [15:0] moved_addr(input logic [15:0] a, input logic [7:0] mode);
`ifdef DMA_BANK_ADDR_HOLD_EN
    if (mode[3]) return a;
`endif
    return mode[5] ? a - 16'd1 : a + 16'd1;
  endfunction

  task automatic model_clock();
    logic w, r, clr;
    logic [3:0] set;
    int unsigned c;
    if (!rst_n || mclr) begin
      for (int i = 0; i < 4; i++) begin
        m_base_addr[i] = '0; m_base_cnt[i] = '0;
        m_cur_addr[i]  = '0; m_cur_cnt[i]  = '0; m_mode[i] = '0;
      end
      m_ptr = 0; m_dout = '0; m_tcp = '0; m_tcs = '0;
      return;
    end
    w = cpu_wr;
    r = cpu_rd && !cpu_wr;
    clr = 1'b0;
    set = '0;
    if (r) begin
      case (reg_sel)
        2'd0: m_dout = 8'(m_cur_addr[ch_sel] >> (8 * m_ptr));
        2'd1: m_dout = 8'(m_cur_cnt[ch_sel] >> (8 * m_ptr));
        2'd2: m_dout = m_mode[ch_sel];
        default: begin m_dout = {4'b0, m_tcs}; clr = 1'b1; end
      endcase
    end
    m_tcp = '0;
    if (step && !(w && reg_sel != 2'd3 && ch_sel == xfer_ch)) begin
      c = xfer_ch;
      if (m_cur_cnt[c] == 16'd0) begin
        m_tcp[c] = 1'b1;
        set[c] = 1'b1;
        if (m_mode[c][4]) begin
          m_cur_addr[c] = m_base_addr[c];
          m_cur_cnt[c]  = m_base_cnt[c];
        end else begin
          m_cur_addr[c] = moved_addr(m_cur_addr[c], m_mode[c]);
          m_cur_cnt[c]  = 16'hFFFF;
        end
      end else begin
        m_cur_addr[c] = moved_addr(m_cur_addr[c], m_mode[c]);
        m_cur_cnt[c]  = m_cur_cnt[c] - 16'd1;
      end
    end
    if (w) begin
      case (reg_sel)
        2'd0: begin
          m_base_addr[ch_sel] = put_byte(m_base_addr[ch_sel], m_ptr, din);
          m_cur_addr[ch_sel]  = put_byte(m_cur_addr[ch_sel], m_ptr, din);
        end
        2'd1: begin
          m_base_cnt[ch_sel] = put_byte(m_base_cnt[ch_sel], m_ptr, din);
          m_cur_cnt[ch_sel]  = put_byte(m_cur_cnt[ch_sel], m_ptr, din);
        end
        2'd2: m_mode[ch_sel] = din & 8'hFC;
        default: ;
      endcase
    end
    if (clr_ptr) m_ptr = 0;
    else if ((cpu_wr || cpu_rd) && reg_sel < 2'd2) m_ptr = (m_ptr + 1) % 2;
    m_tcs = (clr ? 4'b0 : m_tcs) | set;
  endtask

  // One clock: update model with the driven inputs, clock the DUT, release strobes.
  task automatic cyc();
    model_clock();
    @(posedge clk);
    #1;
    cpu_wr = 1'b0; cpu_rd = 1'b0; clr_ptr = 1'b0; step = 1'b0; mclr = 1'b0;
  endtask

  task automatic do_write(input logic [1:0] s, input logic [1:0] ch, input logic [7:0] d);
    cpu_wr = 1'b1; reg_sel = s; ch_sel = ch; din = d;
    cyc();
  endtask

  task automatic do_read(input logic [1:0] s, input logic [1:0] ch);
    cpu_rd = 1'b1; reg_sel = s; ch_sel = ch;
    cyc();
  endtask

  task automatic do_step(input logic [1:0] ch);
    step = 1'b1; xfer_ch = ch;
    cyc();
  endtask

  task automatic write_reg16(input logic [1:0] s, input logic [1:0] ch, input logic [15:0] v);
    clr_ptr = 1'b1;
    cyc();
    do_write(s, ch, v[7:0]);
    do_write(s, ch, v[15:8]);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
    checks++; if (dout !== 8'h00) begin failures++; $display("FAIL reset_dout got=%0h exp=0", dout); end
    checks++; if (tc_status !== 4'h0) begin failures++; $display("FAIL reset_tcstatus got=%0h exp=0", tc_status); end
    checks++; if (byte_ptr !== 1'b0) begin failures++; $display("FAIL reset_ptr got=%0h exp=0", byte_ptr); end
    checks++; if (tc_pulse !== 4'h0) begin failures++; $display("FAIL reset_tcpulse got=%0h exp=0", tc_pulse); end
    do_read(2'd0, 2'd0);
    checks++; if (dout !== 8'h00) begin failures++; $display("FAIL reset_rd0 got=%0h exp=0", dout); end
    checks++; if (byte_ptr !== 1'b1) begin failures++; $display("FAIL reset_rd0_ptr got=%0h exp=1", byte_ptr); end
    do_read(2'd0, 2'd0);
    checks++; if (dout !== 8'h00) begin failures++; $display("FAIL reset_rd1 got=%0h exp=0", dout); end
    checks++; if (byte_ptr !== 1'b0) begin failures++; $display("FAIL reset_rd1_ptr got=%0h exp=0", byte_ptr); end
  endtask

  task automatic test_byte_ptr();
    do_read(2'd1, 2'd0);
    clr_ptr = 1'b1;
    cyc();
    checks++; if (byte_ptr !== 1'b0) begin failures++; $display("FAIL bp_clear got=%0h exp=0", byte_ptr); end
    do_write(2'd0, 2'd2, 8'h34);
    checks++; if (byte_ptr !== 1'b1) begin failures++; $display("FAIL bp_wr0 got=%0h exp=1", byte_ptr); end
    do_write(2'd0, 2'd2, 8'h12);
    checks++; if (byte_ptr !== 1'b0) begin failures++; $display("FAIL bp_wr1 got=%0h exp=0", byte_ptr); end
    do_read(2'd0, 2'd2);
    checks++; if (dout !== 8'h34) begin failures++; $display("FAIL bp_rd_lo got=%0h exp=34", dout); end
    do_read(2'd0, 2'd2);
    checks++; if (dout !== 8'h12) begin failures++; $display("FAIL bp_rd_hi got=%0h exp=12", dout); end
    checks++; if (byte_ptr !== 1'b0) begin failures++; $display("FAIL bp_wrap got=%0h exp=0", byte_ptr); end
    // Clear beats an advance; mode and status accesses leave the pointer alone.
    clr_ptr = 1'b1; cpu_rd = 1'b1; reg_sel = 2'd0; ch_sel = 2'd2;
    cyc();
    do_write(2'd2, 2'd0, 8'h00);
    do_read(2'd3, 2'd0);
    checks++; if (byte_ptr !== 1'b0) begin failures++; $display("FAIL bp_prio got=%0h exp=0", byte_ptr); end
    cpu_wr = 1'b1; cpu_rd = 1'b1; reg_sel = 2'd1; ch_sel = 2'd2; din = 8'h00;
    cyc();
    checks++; if (byte_ptr !== 1'b1) begin failures++; $display("FAIL bp_wr_rd_once got=%0h exp=1", byte_ptr); end
  endtask

  task automatic test_decrement();
    logic [15:0] exp_a [3];
    exp_a[0] = 16'h0FFF; exp_a[1] = 16'h0FFE; exp_a[2] = 16'h0FFD;
    write_reg16(2'd0, 2'd1, 16'h1000);
    write_reg16(2'd1, 2'd1, 16'h0002);
    do_write(2'd2, 2'd1, 8'h20);
    for (int k = 0; k < 3; k++) begin
      do_step(2'd1);
      checks++;
      if (cur_addr !== exp_a[k]) begin failures++; $display("FAIL dec_addr step=%0d got=%0h exp=%0h", k, cur_addr, exp_a[k]); end
      checks++;
      if (tc_pulse[1] !== (k == 2)) begin failures++; $display("FAIL dec_tcpulse step=%0d got=%0b exp=%0b", k, tc_pulse[1], k == 2); end
    end
    checks++; if (cur_count !== 16'hFFFF) begin failures++; $display("FAIL dec_count got=%0h exp=ffff", cur_count); end
    checks++; if (tc_status[1] !== 1'b1) begin failures++; $display("FAIL dec_tcstatus got=%0b exp=1", tc_status[1]); end
    cyc();
    checks++; if (tc_pulse !== 4'h0) begin failures++; $display("FAIL dec_pulse_width got=%0h exp=0", tc_pulse); end
  endtask

  task automatic test_autoinit();
    write_reg16(2'd0, 2'd3, 16'h00F0);
    write_reg16(2'd1, 2'd3, 16'h0001);
    do_write(2'd2, 2'd3, 8'h10);
    checks++; if (auto_init !== 4'b1000) begin failures++; $display("FAIL ai_bits got=%0b exp=1000", auto_init); end
    do_step(2'd3);
    checks++; if (cur_addr !== 16'h00F1) begin failures++; $display("FAIL ai_s1_addr got=%0h exp=f1", cur_addr); end
    do_step(2'd3);
    checks++; if (tc_pulse !== 4'b1000) begin failures++; $display("FAIL ai_tc got=%0b exp=1000", tc_pulse); end
    checks++; if (cur_addr !== 16'h00F0) begin failures++; $display("FAIL ai_reload_addr got=%0h exp=f0", cur_addr); end
    checks++; if (cur_count !== 16'h0001) begin failures++; $display("FAIL ai_reload_cnt got=%0h exp=1", cur_count); end
    do_step(2'd3);
    checks++; if (cur_addr !== 16'h00F1) begin failures++; $display("FAIL ai_s3_addr got=%0h exp=f1", cur_addr); end
  endtask

  task automatic test_status_tc();
    do_read(2'd3, 2'd0);
    checks++; if (dout !== 8'b0000_1010) begin failures++; $display("FAIL st_read got=%0h exp=0a", dout); end
    checks++; if (tc_status !== 4'h0) begin failures++; $display("FAIL st_cleared got=%0h exp=0", tc_status); end
    write_reg16(2'd0, 2'd0, 16'h0000);
    write_reg16(2'd1, 2'd0, 16'h0000);
    cpu_rd = 1'b1; reg_sel = 2'd3; ch_sel = 2'd0; step = 1'b1; xfer_ch = 2'd0;
    cyc();
    checks++; if (tc_status !== 4'b0001) begin failures++; $display("FAIL st_set_wins got=%0b exp=0001", tc_status); end
    checks++; if (dout !== 8'h00) begin failures++; $display("FAIL st_same_cycle_dout got=%0h exp=0", dout); end
    write_reg16(2'd1, 2'd0, 16'h0000);
    clr_ptr = 1'b1;
    cyc();
    cpu_wr = 1'b1; reg_sel = 2'd0; ch_sel = 2'd0; din = 8'hAB; step = 1'b1; xfer_ch = 2'd0;
    cyc();
    checks++; if (tc_pulse !== 4'h0) begin failures++; $display("FAIL wr_step_no_tc got=%0h exp=0", tc_pulse); end
    checks++; if (cur_addr !== 16'h00AB) begin failures++; $display("FAIL wr_step_addr got=%0h exp=ab", cur_addr); end
    checks++; if (cur_count !== 16'h0000) begin failures++; $display("FAIL wr_step_cnt got=%0h exp=0", cur_count); end
  endtask

  task automatic test_addr_hold();
    logic [15:0] exp_addr;
`ifdef DMA_BANK_ADDR_HOLD_EN
    exp_addr = 16'h0200;
`else
    exp_addr = 16'h0204;
`endif
    write_reg16(2'd0, 2'd2, 16'h0200);
    write_reg16(2'd1, 2'd2, 16'h0010);
    do_write(2'd2, 2'd2, 8'h08);
    for (int k = 0; k < 4; k++) do_step(2'd2);
    checks++; if (cur_addr !== exp_addr) begin failures++; $display("FAIL hold_addr got=%0h exp=%0h", cur_addr, exp_addr); end
    checks++; if (cur_count !== 16'h000C) begin failures++; $display("FAIL hold_cnt got=%0h exp=c", cur_count); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      rst_n   = ($urandom_range(0, 199) != 0);
      mclr    = ($urandom_range(0, 149) == 0);
      clr_ptr = ($urandom_range(0, 19) == 0);
      cpu_wr  = ($urandom_range(0, 2) == 0);
      cpu_rd  = ($urandom_range(0, 2) == 0);
      reg_sel = 2'($urandom_range(0, 3));
      ch_sel  = 2'($urandom_range(0, 3));
      din     = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'($urandom_range(0, 3));
      step    = ($urandom_range(0, 1) == 0);
      xfer_ch = 2'($urandom_range(0, 3));
      cyc();
      rst_n = 1'b1;
      checks++; if (dout !== m_dout) begin failures++; $display("FAIL rnd_dout n=%0d got=%0h exp=%0h", n, dout, m_dout); end
      checks++; if (byte_ptr !== 1'(m_ptr)) begin failures++; $display("FAIL rnd_ptr n=%0d got=%0h exp=%0h", n, byte_ptr, m_ptr); end
      checks++; if (tc_pulse !== m_tcp) begin failures++; $display("FAIL rnd_tcp n=%0d got=%0h exp=%0h", n, tc_pulse, m_tcp); end
      checks++; if (tc_status !== m_tcs) begin failures++; $display("FAIL rnd_tcs n=%0d got=%0h exp=%0h", n, tc_status, m_tcs); end
      checks++; if (cur_addr !== m_cur_addr[xfer_ch]) begin failures++; $display("FAIL rnd_addr n=%0d got=%0h exp=%0h", n, cur_addr, m_cur_addr[xfer_ch]); end
      checks++; if (cur_count !== m_cur_cnt[xfer_ch]) begin failures++; $display("FAIL rnd_cnt n=%0d got=%0h exp=%0h", n, cur_count, m_cur_cnt[xfer_ch]); end
      checks++;
      if (auto_init !== {m_mode[3][4], m_mode[2][4], m_mode[1][4], m_mode[0][4]}) begin
        failures++; $display("FAIL rnd_autoinit n=%0d got=%0b", n, auto_init);
      end
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; mclr = 1'b0; clr_ptr = 1'b0; cpu_wr = 1'b0; cpu_rd = 1'b0;
    reg_sel = 2'd0; ch_sel = 2'd0; din = 8'h00; step = 1'b0; xfer_ch = 2'd0;
    test_reset();
    test_byte_ptr();
    test_decrement();
    test_autoinit();
    test_status_tc();
    test_addr_hold();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
